// File: rtl/stream_cipher_pkg.sv
// stream_cipher_pkg: shared widths and the FIFO word entry for the cipher output packer
package stream_cipher_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / BYTE_W;
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [2:0]        bytes;
    logic              last;
  } word_entry_t;
endpackage

// File: rtl/stream_cipher_word_fifo.sv
// stream_cipher_word_fifo: first-word-fall-through FIFO of packed words; reads 0 while empty
module stream_cipher_word_fifo
  import stream_cipher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  word_entry_t din,
  output word_entry_t dout,
  output logic        empty,
  output logic        full
);
  localparam int AW = $clog2(DEPTH);
  word_entry_t mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        wr, rd;
  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];
  // storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk)
    if (wr) mem[wptr[AW-1:0]] <= din;
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
endmodule

// File: rtl/stream_cipher_out_packer.sv
// stream_cipher_out_packer: packs cipher bytes into little-endian 32-bit words behind a FWFT FIFO; optional PACKER_BYTE_COUNT_EN adds byte_count
module stream_cipher_out_packer
  import stream_cipher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              flush,
  output logic [WORD_W-1:0] word_out,
  output logic [2:0]        word_bytes,
  output logic              word_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow
`ifdef PACKER_BYTE_COUNT_EN
  ,
  output logic [31:0]       byte_count
`endif
);
  logic [1:0]        idx;
  logic [WORD_W-1:0] pack, pack_next;
  logic              push, pop, empty, full;
  word_entry_t       din, dout;
  // the same-cycle byte lands in its lane before any push decision
  always_comb begin
    pack_next = pack;
    if (byte_valid) pack_next[{idx, 3'b000} +: BYTE_W] = byte_in;
  end
  assign push = flush || (byte_valid && idx == 2'd3);
  assign din  = '{data: pack_next, bytes: {1'b0, idx} + {2'b00, byte_valid}, last: flush};
  assign pop  = word_valid && word_ready;
  stream_cipher_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (din),
    .dout (dout),
    .empty(empty),
    .full (full)
  );
  assign word_valid = !empty;
  assign word_out   = dout.data;
  assign word_bytes = dout.bytes;
  assign word_last  = dout.last;
  // lane index and pack register restart after every push; overflow is sticky until reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx      <= '0;
      pack     <= '0;
      overflow <= 1'b0;
    end else begin
      idx      <= push ? 2'd0 : idx + {1'b0, byte_valid};
      pack     <= push ? '0 : pack_next;
      if (push && full && !pop) overflow <= 1'b1;
    end
`ifdef PACKER_BYTE_COUNT_EN
  // every accepted byte counts, including those in dropped words
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) byte_count <= '0;
    else if (byte_valid) byte_count <= byte_count + 32'd1;
`endif
endmodule

// File: tb/tb_stream_cipher_out_packer.sv
// tb_stream_cipher_out_packer: directed and random stimulus against a queue-based model of the packer
module tb_stream_cipher_out_packer;
  import stream_cipher_pkg::*;
  localparam int DEPTH = 4;
  logic        clk = 0, rst_n = 0, byte_valid = 0, flush = 0, word_ready = 0;
  logic [7:0]  byte_in = 0;
  logic [31:0] word_out;
  logic [2:0]  word_bytes;
  logic        word_last, word_valid, overflow;
`ifdef PACKER_BYTE_COUNT_EN
  logic [31:0] byte_count;
`endif
  always #5 clk = ~clk;
  stream_cipher_out_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(byte_valid),
    .byte_in   (byte_in),
    .flush     (flush),
    .word_out  (word_out),
    .word_bytes(word_bytes),
    .word_last (word_last),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .overflow  (overflow)
`ifdef PACKER_BYTE_COUNT_EN
    ,
    .byte_count(byte_count)
`endif
  );
  word_entry_t q[$];
  logic [7:0]  cur[$];
  bit          ovf_m;
  int unsigned cnt_m;
  int          pass_n = 0, total_n = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic check_all(input string tag);
    word_entry_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk({tag, ".valid"}, {31'b0, word_valid}, {31'b0, q.size() > 0});
    chk({tag, ".data"}, word_out, h.data);
    chk({tag, ".bytes"}, {29'b0, word_bytes}, {29'b0, h.bytes});
    chk({tag, ".last"}, {31'b0, word_last}, {31'b0, h.last});
    chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, ovf_m});
`ifdef PACKER_BYTE_COUNT_EN
    chk({tag, ".cnt"}, byte_count, cnt_m);
`endif
  endtask
  task automatic cyc(input bit bv, input logic [7:0] b, input bit fl, input bit rdy);
    word_entry_t e;
    byte_valid = bv; byte_in = b; flush = fl; word_ready = rdy;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (bv) begin
      cur.push_back(b);
      cnt_m++;
    end
    if (cur.size() == 4 || fl) begin
      e = '0;
      foreach (cur[i]) e.data[8*i +: 8] = cur[i];
      e.bytes = 3'(cur.size());
      e.last = fl;
      cur.delete();
      if (q.size() < DEPTH) q.push_back(e);
      else ovf_m = 1;
    end
    @(posedge clk);
    @(negedge clk);
    check_all("cyc");
  endtask
  task automatic do_reset();
    rst_n = 0; byte_valid = 0; flush = 0; word_ready = 0;
    q.delete(); cur.delete(); ovf_m = 0; cnt_m = 0;
    #1 check_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 1);
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 1);
    idle(3);
    for (int i = 0; i <= 4; i++) cyc(1, 8'(8'hA0 + i), 0, 1);
    cyc(0, 8'h00, 1, 1);
    idle(3);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h44, 1, 0);
    chk("t3.lit.data", word_out, 32'h44332211);
    chk("t3.lit.bytes", {29'b0, word_bytes}, 32'd4);
    chk("t3.lit.last", {31'b0, word_last}, 32'd1);
    cyc(0, 8'h00, 0, 1);
    chk("t3.lit.noterm", {31'b0, word_valid}, 32'd0);
    cyc(0, 8'h00, 1, 0);
    chk("t4.lit.valid", {31'b0, word_valid}, 32'd1);
    chk("t4.lit.data", word_out, 32'h0);
    chk("t4.lit.bytes", {29'b0, word_bytes}, 32'd0);
    chk("t4.lit.last", {31'b0, word_last}, 32'd1);
    idle(2);
    for (int i = 0; i < 20; i++) cyc(1, 8'(i), 0, 0);
    chk("t5.lit.ovf", {31'b0, overflow}, 32'd1);
    chk("t5.lit.head", word_out, 32'h03020100);
    idle(6);
    chk("t5.lit.ovf_sticky", {31'b0, overflow}, 32'd1);
    cyc(1, 8'hE0, 0, 0);
    cyc(1, 8'hE1, 0, 0);
    cyc(1, 8'hE2, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h55 + i), 0, 0);
    chk("t6.lit.data", word_out, 32'h58575655);
    chk("t6.lit.bytes", {29'b0, word_bytes}, 32'd4);
`ifdef PACKER_BYTE_COUNT_EN
    chk("t6.lit.cnt", byte_count, 32'd4);
`endif
    idle(2);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
          ((i / 50) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0));
    idle(6);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
